code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Upstream stage of the processor datapath.
- Receives a byte stream over a valid/ready interface (e.g. from a UART receiver), assembles 16-bit instruction words, and writes them into code memory through the datapath's code_w_en / code_addr_in / code_in port.
- Raises run when the whole image has been loaded.
- Holds the processor stopped while loading, or after a protocol error.

Parameters:
- ADDR_W, 9, code memory address width; capacity is 2**ADDR_W words.
- CNT_W, 10, width of the word counter; must be ADDR_W+1 so that a full-memory count is representable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- restart  input  1  synchronous request to reload; honoured only in DONE or ERROR.
- code_w_en  output  1  code memory write strobe, one cycle per word.
- code_addr_in  output  ADDR_W  code memory write address.
- code_in  output  16  code memory write data.
- run  output  1  processor enable; high only in DONE.
- busy  output  1  high in any state other than IDLE, DONE or ERROR.
- error  output  1  high only in ERROR.
- words_loaded  output  CNT_W  number of words written since the last IDLE.

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock, and rst_n asserted low immediately forces the following, regardless of the state at the time of reset (including mid-load):
  - state = IDLE
  - all outputs 0, except in_ready = 1
  - internal count, address and assembly registers = 0
- Frame format:
  - byte 0: count high; byte 1: count low. N = 16-bit count.
  - then 2N payload bytes, each word sent high byte first.
  - [checksum byte, only when the optional feature is enabled].
- States and transitions:
  - IDLE: in_ready=1. On a byte transfer: latch count[15:8] -> CNT_LO.
  - CNT_LO: in_ready=1. On a byte transfer: latch count[7:0]. Then:
    - N = 0 -> DONE (or CHECK when the feature is enabled).
    - N > 2**ADDR_W -> ERROR.
    - otherwise -> DATA_HI.
  - DATA_HI: in_ready=1. On a byte transfer: word[15:8] = byte -> DATA_LO.
  - DATA_LO: in_ready=1. On a byte transfer: word[7:0] = byte -> WRITE.
  - WRITE: in_ready=0 and code_w_en=1 for exactly this one cycle.
    - code_addr_in = current address; code_in = assembled word.
    - On exit: address += 1, words_loaded += 1.
    - If words_loaded+1 == N -> DONE (or CHECK); else -> DATA_HI.
  - DONE: run=1, in_ready=0. restart=1 -> IDLE; run drops on the next cycle and address and words_loaded clear.
  - ERROR: error=1, run=0, in_ready=0. restart=1 -> IDLE.
- Output timing:
  - code_w_en, code_addr_in and code_in are registered; they are stable for the whole WRITE cycle and are 0 outside WRITE.
  - Latency: code_w_en rises 1 cycle after the low byte is accepted.
  - Peak throughput: one word per 3 cycles.
- Bytes offered while in_ready=0 are not consumed; in_valid may stay high across WRITE without loss.
- Address arithmetic is unsigned ADDR_W bits. With N = 2**ADDR_W, the last write goes to address 2**ADDR_W-1; the address then wraps to 0 but is unused.
- Bytes arriving after DONE or ERROR are back-pressured; they are never dropped silently.
- restart in any other state is ignored.

Optional Feature:
- Macro: CODE_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of every accepted byte (count bytes and payload) is kept; it clears in IDLE.
  - After the last WRITE (or after CNT_LO when N=0), the loader enters CHECK with in_ready=1.
  - The next accepted byte is compared with the running XOR: equal -> DONE, different -> ERROR.
- Disabled: the CHECK state and the XOR register do not exist; the loader goes straight to DONE.

Test Plan:
- Reset mid-frame: after 3 bytes, pulse rst_n low -> outputs immediately at reset values. Send count 0x0001 then words 0xA5 0x5A -> one write, addr 0, data 0xA55A, then run=1.
- Count 0x0003, payload 0x12 0x34 0xAB 0xCD 0xFF 0x00 with in_valid held high -> writes 0x1234@0, 0xABCD@1, 0xFF00@2; each code_w_en exactly 1 cycle; words_loaded=3; run=1.
- Count 0x0000 -> no write; run=1 (checksum build: after a checksum byte of 0x00).
- Count 0x0201 -> ERROR, error=1, run=0, in_ready=0. restart=1 -> IDLE, in_ready=1.
- Full memory: count 0x0200 with 1024 random bytes -> last write at addr 0x1FF; run=1; bytes offered afterwards are not accepted.
- CODE_LOADER_CHECKSUM_EN: count 0x0001, payload 0x0F 0xF0, checksum 0xFE -> DONE. Same frame with checksum 0x00 -> ERROR.

Source files
------------

// File: rtl/code_loader.sv
// Byte-stream code loader: assembles 16-bit words from a count-prefixed byte frame and
// writes them to code memory. Optional trailing XOR checksum via CODE_LOADER_CHECKSUM_EN.
module code_loader #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr_in,
    output logic [15:0]       code_in,
    output logic              run,
    output logic              busy,
    output logic              error,
    output logic [CNT_W-1:0]  words_loaded,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid & in_ready are both high;
    // in_ready depends only on the registered state, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CNT_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
`ifdef CODE_LOADER_CHECKSUM_EN
        , S_CHECK = 3'd7
`endif
    } state_t;

    localparam logic [16:0] LIMIT = 17'(1) << ADDR_W;

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_fin_state;
    logic [7:0]          r_cnt_hi;
    logic [7:0]          r_word_hi;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_words;
    logic [CNT_W-1:0]    w_words_inc;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_code_w_en;
    logic [ADDR_W-1:0]   r_code_addr;
    logic [15:0]         r_code_in;
    logic [15:0]         w_n;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0]          r_xor;
`endif

    assign w_n         = {r_cnt_hi, in_data};
    assign w_words_inc = r_words + CNT_W'(1);
`ifdef CODE_LOADER_CHECKSUM_EN
    assign w_fin_state = S_CHECK;
`else
    assign w_fin_state = S_DONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        run          = 1'b0;
        busy         = 1'b0;
        error        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_CNT_LO;
            end
            S_CNT_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (w_n == 16'd0)               w_next_state = w_fin_state;
                    else if ({1'b0, w_n} > LIMIT)   w_next_state = S_ERROR;
                    else                            w_next_state = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next_state = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                if (w_words_inc == r_count) w_next_state = w_fin_state;
                else                        w_next_state = S_DATA_HI;
            end
            S_DONE: begin
                run = 1'b1;
                if (restart) w_next_state = S_IDLE;
            end
            S_ERROR: begin
                error = 1'b1;
                if (restart) w_next_state = S_IDLE;
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_next_state = (in_data == r_xor) ? S_DONE : S_ERROR;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // Write strobe, address and data are loaded on the low-byte transfer so they are
    // registered and stable for the whole WRITE cycle, and zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_hi    <= '0;
            r_word_hi   <= '0;
            r_count     <= '0;
            r_words     <= '0;
            r_addr      <= '0;
            r_code_w_en <= 1'b0;
            r_code_addr <= '0;
            r_code_in   <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_code_w_en <= 1'b0;
            r_code_addr <= '0;
            r_code_in   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt_hi <= in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_xor    <= in_data;
`endif
                    end
                end
                S_CNT_LO: begin
                    if (in_valid) begin
                        r_count <= w_n[CNT_W-1:0];
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_xor   <= r_xor ^ in_data;
`endif
                    end
                end
                S_DATA_HI: begin
                    if (in_valid) begin
                        r_word_hi <= in_data;
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_xor     <= r_xor ^ in_data;
`endif
                    end
                end
                S_DATA_LO: begin
                    if (in_valid) begin
                        r_code_w_en <= 1'b1;
                        r_code_addr <= r_addr;
                        r_code_in   <= {r_word_hi, in_data};
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_xor       <= r_xor ^ in_data;
`endif
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_words <= w_words_inc;
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        r_cnt_hi  <= '0;
                        r_word_hi <= '0;
                        r_count   <= '0;
                        r_words   <= '0;
                        r_addr    <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
                        r_xor     <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign code_w_en    = r_code_w_en;
    assign code_addr_in = r_code_addr;
    assign code_in      = r_code_in;
    assign words_loaded = r_words;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_code_loader.sv
// Scoreboarded bench for code_loader: a frame-level model queues expected writes,
// a negedge monitor pops and compares them.
module tb_code_loader;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 10;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              restart;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr_in;
    logic [15:0]       code_in;
    logic              run;
    logic              busy;
    logic              error;
    logic [CNT_W-1:0]  words_loaded;
    logic [2:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W+15:0] exp_q[$];
    logic [7:0]         pl_q[$];
    logic               prev_en;

    code_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .restart(restart), .code_w_en(code_w_en),
        .code_addr_in(code_addr_in), .code_in(code_in), .run(run), .busy(busy),
        .error(error), .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (code_w_en) begin
                chk("w_en_single_cycle", {31'd0, prev_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {7'd0, code_addr_in, code_in}, 32'hFFFF_FFFF);
                end else begin
                    chk("write_addr_data", {7'd0, code_addr_in, code_in}, {7'd0, exp_q.pop_front()});
                end
            end else begin
                chk("idle_addr_data_zero", {7'd0, code_addr_in, code_in}, 32'd0);
            end
            prev_en = code_w_en;
        end
    end

    // drivers
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        else @(posedge clk);
    endtask

    task automatic check_outcome(input bit exp_err, input int exp_words);
        int t;
        idle(1);
        t = 0;
        while (!(run || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        idle(2);
        chk("run", {31'd0, run}, {31'd0, !exp_err});
        chk("error", {31'd0, error}, {31'd0, exp_err});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("in_ready_end", {31'd0, in_ready}, 32'd0);
        chk("words_loaded", {22'd0, words_loaded}, exp_words);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        // offered bytes must be held off
        @(negedge clk);
        in_data  = 8'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("backpressure", {31'd0, in_ready}, 32'd0);
        end
        chk("run_hold", {31'd0, run}, {31'd0, !exp_err});
        idle(1);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rs_run", {31'd0, run}, 32'd0);
        chk("rs_error", {31'd0, error}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_words", {22'd0, words_loaded}, 32'd0);
    endtask

    // Model: N > capacity errors out right after the count; otherwise word i lands at
    // address i. The checksum is the XOR of every count and payload byte.
    task automatic run_frame(input int n, input bit gaps, input bit ck_force, input logic [7:0] ck_val);
        bit         exp_err;
        int         exp_words;
        logic [7:0] x;
        logic [7:0] ck;
        logic [15:0] nn;
        nn = 16'(n);
        exp_err = (n > CAP);
        exp_words = 0;
        x = nn[15:8] ^ nn[7:0];
        send_byte(nn[15:8], gaps);
        send_byte(nn[7:0], gaps);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({ADDR_W'(i), pl_q[2*i], pl_q[2*i+1]});
                x = x ^ pl_q[2*i] ^ pl_q[2*i+1];
                send_byte(pl_q[2*i], gaps);
                send_byte(pl_q[2*i+1], gaps);
            end
            exp_words = n;
`ifdef CODE_LOADER_CHECKSUM_EN
            ck = ck_force ? ck_val : x;
            send_byte(ck, gaps);
            exp_err = (ck != x);
`else
            ck = ck_val;
            if (ck_force && ck == x) exp_words = n;
`endif
        end
        check_outcome(exp_err, exp_words);
    endtask

    task automatic rand_payload(input int n);
        pl_q.delete();
        if (n <= CAP) for (int i = 0; i < 2 * n; i++) pl_q.push_back(8'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; restart = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outs", {code_w_en, run, busy, error, 6'd0, words_loaded}, 32'd0);
        rst_n = 1'b1;

        // reset mid-frame, then a one-word frame
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_outs", {code_w_en, run, busy, error, 6'd0, words_loaded}, 32'd0);
        chk("async_rst_addr_data", {7'd0, code_addr_in, code_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pl_q = '{8'hA5, 8'h5A};
        run_frame(1, 0, 0, 8'h00);
        do_restart();

        // three words, valid held high through WRITE cycles
        pl_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'h00};
        run_frame(3, 0, 0, 8'h00);
        do_restart();

        // empty image
        pl_q.delete();
        run_frame(0, 0, 1, 8'h00);
        do_restart();

        // oversize count
        run_frame(CAP + 1, 0, 0, 8'h00);
        do_restart();

        // full memory
        rand_payload(CAP);
        run_frame(CAP, 0, 0, 8'h00);
        do_restart();

`ifdef CODE_LOADER_CHECKSUM_EN
        pl_q = '{8'h0F, 8'hF0};
        run_frame(1, 0, 1, 8'hFE);
        do_restart();
        pl_q = '{8'h0F, 8'hF0};
        run_frame(1, 0, 1, 8'h00);
        do_restart();
`endif

        // randomized frames with gaps
        for (int k = 0; k < 12; k++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(CAP + 1, 65535)) : int'($urandom_range(0, 24));
            rand_payload(n);
            run_frame(n, 1, $urandom_range(0, 3) == 0, 8'($urandom));
            do_restart();
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
